// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Registered command stage, tag pipeline matching RAM read latency, per-port return stage.
module ram_arbiter #(
   parameter int SZ = 32,
   parameter int N  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rvalid0,
   output logic         rvalid1,
   output logic [N-1:0] rdata0,
   output logic [N-1:0] rdata1,
   output logic         rerr0,
   output logic         rerr1,
   output logic         ram_rw,
   output logic [N-1:0] ram_addr,
   output logic [N-1:0] ram_i,
   input  logic [N-1:0] ram_o
);

   localparam int         NP   = 2;
   localparam logic [N:0] SZ_L = (N+1)'(SZ);

   typedef struct packed {
      logic rd;
      logic own;
      logic oor;
   } tag_t;

   logic [NP-1:0]        req, we, gnt, rvalid_w, rerr_w;
   logic [NP-1:0][N-1:0] addr, wdata, rdata_w;
   logic                 last_q, last_d;
   logic                 acc, sel, sel_oor;
   logic                 ram_rw_q, ram_rw_d;
   logic [N-1:0]         ram_addr_q, ram_addr_d, ram_i_q, ram_i_d;
   tag_t                 tag1_q, tag1_d, tag2_q;

   assign req   = {req1, req0};
   assign we    = {we1, we0};
   assign addr  = {addr1, addr0};
   assign wdata = {wdata1, wdata0};

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      gnt = '0;
      if (reset) begin
         gnt[0] = req[0] & (~req[1] | last_q);
         gnt[1] = req[1] & (~req[0] | ~last_q);
      end
   end

   assign acc     = |gnt;
   assign sel     = gnt[1];
   assign sel_oor = {1'b0, addr[sel]} >= SZ_L;

   always_comb begin
      last_d     = last_q;
      ram_rw_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_i_d    = ram_i_q;
      tag1_d     = '0;
      if (acc) begin
         last_d     = sel;
         ram_rw_d   = we[sel] & ~sel_oor;
         ram_addr_d = sel_oor ? '0 : addr[sel];
         ram_i_d    = wdata[sel];
         tag1_d.rd  = ~we[sel];
         tag1_d.own = sel;
         tag1_d.oor = sel_oor;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q     <= 1'b1;
         ram_rw_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_i_q    <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
      end else begin
         last_q     <= last_d;
         ram_rw_q   <= ram_rw_d;
         ram_addr_q <= ram_addr_d;
         ram_i_q    <= ram_i_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag1_q;
      end
   end

   // tag2 lines up with ram_o: the RAM sampled this tag's command one edge ago.
   for (genvar p = 0; p < NP; p++) begin : g_ret
      logic         hit, vld_q, err_q;
      logic [N-1:0] dat_q;

      assign hit = tag2_q.rd & (tag2_q.own == 1'(p));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
         end else begin
            vld_q <= hit;
            err_q <= hit & tag2_q.oor;
            if (hit) dat_q <= tag2_q.oor ? '0 : ram_o;
         end
      end

      assign rvalid_w[p] = vld_q;
      assign rerr_w[p]   = err_q;
      assign rdata_w[p]  = dat_q;
   end

   assign gnt0     = gnt[0];
   assign gnt1     = gnt[1];
   assign rvalid0  = rvalid_w[0];
   assign rvalid1  = rvalid_w[1];
   assign rerr0    = rerr_w[0];
   assign rerr1    = rerr_w[1];
   assign rdata0   = rdata_w[0];
   assign rdata1   = rdata_w[1];
   assign ram_rw   = ram_rw_q;
   assign ram_addr = ram_addr_q;
   assign ram_i    = ram_i_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, grant-order memory model and per-port response queues.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic       gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, ram_rw;
   logic [7:0] rdata0, rdata1, ram_addr, ram_i, ram_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   ram_arbiter #(.SZ(32), .N(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .rerr0(rerr0), .rerr1(rerr1),
      .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_i(ram_i), .ram_o(ram_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Physical RAM: one access per edge, registered read data.
   logic [7:0] ram [0:31];
   always @(posedge clk) begin
      if (ram_rw) ram[ram_addr[4:0]] <= ram_i;
      ram_o <= ram[ram_addr[4:0]];
   end

   // Reference model: memory contents in grant order, expected responses per port.
   typedef struct {
      int         due;
      logic [7:0] d;
      logic       e;
   } rsp_t;

   logic [7:0] mm [0:31];
   rsp_t       q0[$], q1[$];
   rsp_t       r, h0, h1;
   logic       m_last = 1'b1;
   logic       exp_rw = 0;
   logic [7:0] exp_addr = 0, exp_i = 0;
   logic       e0, e1, s, w, oor;
   logic [7:0] a, d;
   bit         acc0 = 0, acc1 = 0, due0, due1;

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram[i] = 8'($urandom);
         mm[i]  = ram[i];
      end
      ram_o = 8'h00;
   end

   always @(negedge clk) begin
      if (!reset) begin
         q0.delete(); q1.delete();
         m_last = 1'b1; exp_rw = 0; exp_addr = 0; exp_i = 0; acc0 = 0; acc1 = 0;
         n_cmp++;
         if ({gnt0, gnt1, ram_rw, rvalid0, rvalid1, rerr0, rerr1} !== 7'b0 || ram_addr !== 8'h0 ||
             ram_i !== 8'h0 || rdata0 !== 8'h0 || rdata1 !== 8'h0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b%b ram_rw=%b ram_addr=%h ram_i=%h rvalid=%b%b rerr=%b%b rdata=%h/%h, want all 0",
                     gnt0, gnt1, ram_rw, ram_addr, ram_i, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1);
         end
      end else begin
         n_cmp++;
         if (ram_rw !== exp_rw || ram_addr !== exp_addr || ram_i !== exp_i) begin
            n_err++;
            $display("FAIL ram_cmd cyc %0d: got rw=%b addr=%h i=%h want rw=%b addr=%h i=%h",
                     cyc, ram_rw, ram_addr, ram_i, exp_rw, exp_addr, exp_i);
         end
         due0 = q0.size() > 0 && q0[0].due == cyc;
         due1 = q1.size() > 0 && q1[0].due == cyc;
         if (due0) h0 = q0.pop_front();
         if (due1) h1 = q1.pop_front();
         n_cmp++;
         if (rvalid0 !== due0 || (due0 && (rdata0 !== h0.d || rerr0 !== h0.e))) begin
            n_err++;
            $display("FAIL resp0 cyc %0d: got rvalid=%b rdata=%h rerr=%b want rvalid=%b rdata=%h rerr=%b",
                     cyc, rvalid0, rdata0, rerr0, due0, h0.d, h0.e);
         end
         n_cmp++;
         if (rvalid1 !== due1 || (due1 && (rdata1 !== h1.d || rerr1 !== h1.e))) begin
            n_err++;
            $display("FAIL resp1 cyc %0d: got rvalid=%b rdata=%h rerr=%b want rvalid=%b rdata=%h rerr=%b",
                     cyc, rvalid1, rdata1, rerr1, due1, h1.d, h1.e);
         end
         e0 = req0 && (!req1 || m_last);
         e1 = req1 && (!req0 || !m_last);
         n_cmp++;
         if (gnt0 !== e0 || gnt1 !== e1) begin
            n_err++;
            $display("FAIL grant cyc %0d: got gnt=%b%b want %b%b", cyc, gnt0, gnt1, e0, e1);
         end
         acc0 = e0; acc1 = e1;
         if (e0 || e1) begin
            s = e1;
            w = s ? we1 : we0;
            a = s ? addr1 : addr0;
            d = s ? wdata1 : wdata0;
            oor = a >= 8'd32;
            exp_rw = w && !oor; exp_addr = oor ? 8'h0 : a; exp_i = d; m_last = s;
            if (w && !oor) mm[a[4:0]] = d;
            if (!w) begin
               r.due = cyc + 3; r.d = oor ? 8'h00 : mm[a[4:0]]; r.e = oor;
               if (s) q1.push_back(r); else q0.push_back(r);
            end
         end else begin
            exp_rw = 0;
         end
      end
   end

   task automatic issue(input int p, input logic wi, input logic [7:0] ai, input logic [7:0] di, output int gcyc);
      bit got = 0;
      gcyc = -1;
      @(posedge clk); #1;
      if (p == 0) begin req0 = 1; we0 = wi; addr0 = ai; wdata0 = di; end
      else        begin req1 = 1; we1 = wi; addr1 = ai; wdata1 = di; end
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if ((p == 0) ? gnt0 : gnt1) begin got = 1; gcyc = cyc; end
      end
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL issue_timeout: port %0d got no gnt within 4 cycles", p); end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
   endtask

   task automatic test_reset();
      req0 = 1; req1 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 8'h11;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (gnt0 !== 0 || gnt1 !== 0) begin n_err++; $display("FAIL rst_gnt: got %b%b want 00", gnt0, gnt1); end
      n_cmp++;
      if (ram_rw !== 0 || ram_addr !== 0 || ram_i !== 0) begin
         n_err++; $display("FAIL rst_ram: got rw=%b addr=%h i=%h want 0", ram_rw, ram_addr, ram_i);
      end
      @(posedge clk); #1;
      req0 = 0; req1 = 0; reset = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ram_rw !== 0 || gnt0 !== 0 || gnt1 !== 0) begin
            n_err++; $display("FAIL idle_after_rst: got rw=%b gnt=%b%b want 0", ram_rw, gnt0, gnt1);
         end
      end
      @(posedge clk); #1;
      reset = 0; req0 = 1; we0 = 0; addr0 = 8'd0; req1 = 1; we1 = 0; addr1 = 8'd1;
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if (gnt0 !== 1 || gnt1 !== 0) begin n_err++; $display("FAIL first_tie: got gnt=%b%b want 10", gnt0, gnt1); end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_write_read();
      int tg, tv = -1;
      bit got = 0;
      issue(0, 1, 8'd5, 8'hA5, tg);
      issue(0, 0, 8'd5, 8'h00, tg);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (rvalid0) begin
            got = 1; tv = cyc;
            n_cmp++;
            if (rdata0 !== 8'hA5 || rerr0 !== 0) begin
               n_err++; $display("FAIL wr_rd_data: got rdata0=%h rerr0=%b want a5 0", rdata0, rerr0);
            end
         end
      end
      n_cmp++;
      if (!got || tv != tg + 3) begin n_err++; $display("FAIL wr_rd_latency: got rvalid0 at %0d want %0d", tv, tg + 3); end
   endtask

   task automatic test_alternate();
      int t, p0 = 0, p1 = 0;
      logic [7:0] v1, v2;
      v1 = 8'($urandom); v2 = 8'($urandom);
      issue(0, 1, 8'd1, v1, t);
      issue(1, 1, 8'd2, v2, t);
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 8'd1; req1 = 1; we1 = 0; addr1 = 8'd2;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i < 6) begin
            n_cmp++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
               n_err++; $display("FAIL alt_gnt %0d: got gnt=%b%b want %b%b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1));
            end
         end
         if (rvalid0) begin
            p0++; n_cmp++;
            if (rdata0 !== v1 || rvalid1) begin n_err++; $display("FAIL alt_rd0: got %h rv1=%b want %h 0", rdata0, rvalid1, v1); end
         end
         if (rvalid1) begin
            p1++; n_cmp++;
            if (rdata1 !== v2) begin n_err++; $display("FAIL alt_rd1: got %h want %h", rdata1, v2); end
         end
         if (i == 5) begin @(posedge clk); #1; req0 = 0; req1 = 0; end
      end
      n_cmp++;
      if (p0 != 3 || p1 != 3) begin n_err++; $display("FAIL alt_count: got %0d/%0d pulses want 3/3", p0, p1); end
   endtask

   task automatic test_raw();
      int t = -1;
      bit got = 0;
      @(posedge clk); #1;
      req1 = 1; we1 = 1; addr1 = 8'd3; wdata1 = 8'h3C;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (gnt1) begin got = 1; t = cyc; end
      end
      @(posedge clk); #1;
      req1 = 0; req0 = 1; we0 = 0; addr0 = 8'd3;
      @(negedge clk);
      n_cmp++;
      if (!got || gnt0 !== 1) begin n_err++; $display("FAIL raw_gnt: got gnt0=%b (wr granted=%b) want 1", gnt0, got); end
      @(posedge clk); #1;
      req0 = 0;
      while (cyc < t + 4) @(negedge clk);
      n_cmp++;
      if (rvalid0 !== 1 || rdata0 !== 8'h3C) begin
         n_err++; $display("FAIL raw_data: got rvalid0=%b rdata0=%h want 1 3c", rvalid0, rdata0);
      end
   endtask

   task automatic test_oor();
      int t, diffs = 0;
      logic [7:0] snap [0:31];
      issue(0, 0, 8'd40, 8'h00, t);
      @(negedge clk);
      n_cmp++;
      if (ram_rw !== 0 || ram_addr !== 0) begin n_err++; $display("FAIL oor_rd_cmd: got rw=%b addr=%h want 0 00", ram_rw, ram_addr); end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rvalid0 !== 1 || rerr0 !== 1 || rdata0 !== 8'h00) begin
         n_err++; $display("FAIL oor_rd_rsp: got rvalid0=%b rerr0=%b rdata0=%h want 1 1 00", rvalid0, rerr0, rdata0);
      end
      snap = ram;
      issue(0, 1, 8'd40, 8'h5A, t);
      @(negedge clk);
      n_cmp++;
      if (ram_rw !== 0) begin n_err++; $display("FAIL oor_wr_cmd: got rw=%b want 0", ram_rw); end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 32; i++) if (ram[i] !== snap[i]) diffs++;
      n_cmp++;
      if (diffs != 0) begin n_err++; $display("FAIL oor_wr_mem: got %0d changed words want 0", diffs); end
   endtask

   task automatic test_random();
      bit p0 = 0, p1 = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (p0 && acc0) begin p0 = 0; req0 = 0; end
         if (p1 && acc1) begin p1 = 0; req1 = 0; end
         if (!p0 && $urandom_range(3) != 0) begin
            p0 = 1; req0 = 1; we0 = 1'($urandom_range(1)); addr0 = 8'($urandom_range(39)); wdata0 = 8'($urandom);
         end
         if (!p1 && $urandom_range(3) != 0) begin
            p1 = 1; req1 = 1; we1 = 1'($urandom_range(1)); addr1 = 8'($urandom_range(39)); wdata1 = 8'($urandom);
         end
      end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      repeat (6) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int t;
      logic [7:0] saved;
      bit got = 0;
      saved = mm[9];
      @(posedge clk); #1;
      req0 = 1; we0 = 0; addr0 = 8'd7;
      for (int i = 0; i < 4 && !got; i++) begin @(negedge clk); if (gnt0) got = 1; end
      @(posedge clk); #1;
      req0 = 0; req1 = 1; we1 = 1; addr1 = 8'd9; wdata1 = ~saved;
      @(negedge clk);
      n_cmp++;
      if (!got || gnt1 !== 1) begin n_err++; $display("FAIL mid_gnt: got gnt1=%b rd granted=%b want 1 1", gnt1, got); end
      @(posedge clk); #1;
      req1 = 0;
      n_cmp++;
      if (ram_rw !== 1) begin n_err++; $display("FAIL mid_rw_pre: got rw=%b want 1", ram_rw); end
      #1 reset = 0;
      #1;
      n_cmp++;
      if (ram_rw !== 0 || rvalid0 !== 0) begin n_err++; $display("FAIL mid_rw_abort: got rw=%b rvalid0=%b want 0 0", ram_rw, rvalid0); end
      mm[9] = saved;
      @(posedge clk); #1;
      reset = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rvalid0 !== 0 || rvalid1 !== 0) begin n_err++; $display("FAIL mid_no_rsp: got rvalid=%b%b want 00", rvalid0, rvalid1); end
      end
      n_cmp++;
      if (ram[9] !== saved) begin n_err++; $display("FAIL mid_wr_dropped: got mem[9]=%h want %h", ram[9], saved); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_alternate();
      test_raw();
      test_oor();
      test_random();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port synchronous RAM block (registered read data, write-enable `rw`, one access per clock). It accepts read/write commands from two requesters, grants at most one per cycle, and drives the RAM command ports from registers. It tracks each in-flight read and returns the read data to the requester that issued it. It sits between the two client datapaths and one RAM instance and keeps full throughput of one access per cycle.

## Interface
- SZ, 32, RAM depth in words; valid addresses 0..SZ-1
- N, 8, data width and address width; matches RAM `N`

- clk  input  1  rising-edge clock, shared with RAM
- reset  input  1  asynchronous, active-low
- req0, req1  input  1  request; held until the matching gnt
- we0, we1  input  1  1 = write, 0 = read; sampled with req
- addr0, addr1  input  N  word address
- wdata0, wdata1  input  N  write data
- gnt0, gnt1  output  1  combinational grant; the command is accepted at the rising edge where req&gnt is high
- rvalid0, rvalid1  output  1  one-cycle pulse: read data is valid
- rdata0, rdata1  output  N  read data; holds its value between pulses
- rerr0, rerr1  output  1  qualifies rvalid: the read address was ≥ SZ
- ram_rw  output  1  RAM write enable (registered)
- ram_addr  output  N  RAM address (registered)
- ram_i  output  N  RAM write data (registered)
- ram_o  input  N  RAM registered read data

## Operation
- Arbitration:
  - `last` register holds the index of the most recently granted requester.
  - Only one requester active: it is granted.
  - Both active: grant the one ≠ `last`.
  - `last` updates only on a grant.
  - `last` resets to 1, so requester 0 wins the first tie.
- gnt0/gnt1 are mutually exclusive and both 0 while reset is low.
- Issue stage (S1), on an accepted command:
  - ram_addr ← addr, ram_i ← wdata, ram_rw ← we.
  - Out-of-range address (addr ≥ SZ): ram_rw forced 0 and ram_addr forced 0. Writes are silently dropped.
  - No grant: ram_rw ← 0; ram_addr and ram_i hold their values.
  - Tag register captures {valid_read, owner, oor} with valid_read = ~we.
- RAM stage (S2): the RAM samples the S1 outputs. The tag advances to a second tag register.
- Return stage (S3):
  - If the S2 tag has valid_read: rdata_owner ← ram_o (or 0 if oor), rerr_owner ← oor, rvalid_owner ← 1.
  - rvalid of the other requester stays 0.
- Writes produce no response; a write is complete once granted.
- Ordering:
  - Commands execute at the RAM in grant order.
  - A read granted after a write to the same address returns the new data.
  - Two reads to the same address in consecutive cycles both return the current contents.
- Requester protocol: req, we, addr and wdata must stay stable while req=1 and gnt=0. The arbiter does not check this.
- Reset low (asynchronous) clears, mid-pipeline included:
  - all pipeline tags and `last`=1
  - ram_rw=0, ram_addr=0, ram_i=0
  - rvalid*=0, rerr*=0, rdata*=0
  - In-flight reads are dropped and no rvalid is issued for them.
  - Writes already registered on ram_rw are aborted. A write the RAM has already sampled stays in memory.

## Timing
- Accept edge E0 (req&gnt high):
  - ram_* valid after E0.
  - RAM samples at E1; ram_o valid after E1.
  - rdata/rvalid valid after E2.
- Read latency: 3 edges from the accept edge (cycle of gnt = T; rvalid high in T+3).
- Throughput: one command per cycle, back-to-back, with no bubbles under continuous requests.
- Both requesters continuously active: grants alternate 0,1,0,1,…
- First cycle after reset release with both requesting: gnt0.
- Maximum wait for a requester that holds req: 1 cycle.

## Test plan
- Reset → all outputs 0 and both gnt 0 while reset low; after release, with no req, ram_rw stays 0.
- req0 write addr=5 data=0xA5, then req0 read addr=5 → rvalid0 pulses 3 cycles after the read grant, rdata0=0xA5, rerr0=0, rvalid1 never asserts.
- req0 and req1 both held high, reads of addr 1 and 2 for 6 cycles → gnt sequence 0,1,0,1,0,1; rvalid pulses alternate; rdata0=mem[1], rdata1=mem[2].
- req1 write addr=3 data=0x3C granted at T, req0 read addr=3 granted at T+1 → rdata0=0x3C at T+4.
- req0 read addr=40 with SZ=32 → ram_rw=0, rvalid0 with rerr0=1 and rdata0=0x00. A write to addr=40 leaves all RAM words unchanged.
- Read granted, reset pulsed low one cycle later → no rvalid after reset release; ram_rw=0 immediately on reset assertion.
